// File: rtl/axi_stream_comparator.sv
// Lock-step comparator sink for two AXI-Stream sources: pairs one beat from each input and flags data differences.
// Optional build macro AXI_STREAM_COMPARATOR_FIRST_MISMATCH_EN keeps the first mismatch pair instead of the latest.
module axi_stream_comparator #(
  parameter int DATA_BITS  = 32,
  parameter int COUNT_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in1_tvalid,
  output logic                  in1_tready,
  input  logic [DATA_BITS-1:0]  in1_tdata,
  input  logic                  in2_tvalid,
  output logic                  in2_tready,
  input  logic [DATA_BITS-1:0]  in2_tdata,
  output logic                  transfer,
  output logic [COUNT_BITS-1:0] transfer_count,
  output logic                  transfer_mismatch,
  output logic                  transfer_mismatch_latch,
  output logic [DATA_BITS-1:0]  mismatch_tdata1,
  output logic [DATA_BITS-1:0]  mismatch_tdata2
);

  logic                  w_hs;
  logic                  w_data_differs;
  logic                  w_capture;

  logic                  r_transfer;
  logic [COUNT_BITS-1:0] r_transfer_count;
  logic                  r_transfer_mismatch;
  logic                  r_mismatch_latch;
  logic [DATA_BITS-1:0]  r_mismatch_tdata1;
  logic [DATA_BITS-1:0]  r_mismatch_tdata2;

  // Each side is ready only when the other side has data, so a lone valid beat is held, never consumed.
  assign in1_tready     = !rst && in2_tvalid;
  assign in2_tready     = !rst && in1_tvalid;
  assign w_hs           = in1_tvalid && in2_tvalid && !rst;
  assign w_data_differs = (in1_tdata != in2_tdata);

`ifdef AXI_STREAM_COMPARATOR_FIRST_MISMATCH_EN
  assign w_capture = w_hs && w_data_differs && !r_mismatch_latch;
`else
  assign w_capture = w_hs && w_data_differs;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_transfer          <= 1'b0;
      r_transfer_count    <= '0;
      r_transfer_mismatch <= 1'b0;
      r_mismatch_latch    <= 1'b0;
      r_mismatch_tdata1   <= '0;
      r_mismatch_tdata2   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      r_transfer          <= w_hs;
      r_transfer_mismatch <= w_hs && w_data_differs;
      if (w_hs) begin
        r_transfer_count <= r_transfer_count + 1'b1;
      end
      if (w_hs && w_data_differs) begin
        r_mismatch_latch <= 1'b1;
      end
      if (w_capture) begin
        r_mismatch_tdata1 <= in1_tdata;
        r_mismatch_tdata2 <= in2_tdata;
      end
    end
  end

  assign transfer                = r_transfer;
  assign transfer_count          = r_transfer_count;
  assign transfer_mismatch       = r_transfer_mismatch;
  assign transfer_mismatch_latch = r_mismatch_latch;
  assign mismatch_tdata1         = r_mismatch_tdata1;
  assign mismatch_tdata2         = r_mismatch_tdata2;

endmodule

// File: tb/tb_axi_stream_comparator.sv
// Self-checking bench for axi_stream_comparator: directed steps plus random beats against a behavioural model.
// COUNT_BITS is narrowed to 4 so counter wrap is exercised within a short run.
module tb_axi_stream_comparator;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in1_tvalid = 1'b0;
  logic          in1_tready;
  logic [DW-1:0] in1_tdata = '0;
  logic          in2_tvalid = 1'b0;
  logic          in2_tready;
  logic [DW-1:0] in2_tdata = '0;
  logic          transfer;
  logic [CW-1:0] transfer_count;
  logic          transfer_mismatch;
  logic          transfer_mismatch_latch;
  logic [DW-1:0] mismatch_tdata1;
  logic [DW-1:0] mismatch_tdata2;

  axi_stream_comparator #(.DATA_BITS(DW), .COUNT_BITS(CW)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .in1_tvalid              (in1_tvalid),
    .in1_tready              (in1_tready),
    .in1_tdata               (in1_tdata),
    .in2_tvalid              (in2_tvalid),
    .in2_tready              (in2_tready),
    .in2_tdata               (in2_tdata),
    .transfer                (transfer),
    .transfer_count          (transfer_count),
    .transfer_mismatch       (transfer_mismatch),
    .transfer_mismatch_latch (transfer_mismatch_latch),
    .mismatch_tdata1         (mismatch_tdata1),
    .mismatch_tdata2         (mismatch_tdata2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: what an observer of the stream pairs expects to see.
  int          m_count    = 0;
  bit          m_transfer = 0;
  bit          m_mm       = 0;
  bit          m_latch    = 0;
  logic [DW-1:0] m_d1     = '0;
  logic [DW-1:0] m_d2     = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, check readies, step the model, check the registered outputs.
  task automatic cycle(input bit r, input bit v1, input int d1, input bit v2, input int d2);
    bit hs;
    rst        = r;
    in1_tvalid = v1;
    in1_tdata  = DW'(d1);
    in2_tvalid = v2;
    in2_tdata  = DW'(d2);
    #1;
    check("in1_tready", 64'(in1_tready), 64'(!r && v2));
    check("in2_tready", 64'(in2_tready), 64'(!r && v1));
    hs = v1 && v2 && !r;
    @(posedge clk);
    if (r) begin
      m_count = 0; m_transfer = 0; m_mm = 0; m_latch = 0; m_d1 = '0; m_d2 = '0;
    end else begin
      m_transfer = hs;
      m_mm       = hs && (d1 != d2);
      if (hs) m_count = (m_count + 1) % (1 << CW);
      if (m_mm) begin
`ifdef AXI_STREAM_COMPARATOR_FIRST_MISMATCH_EN
        if (!m_latch) begin m_d1 = DW'(d1); m_d2 = DW'(d2); end
`else
        m_d1 = DW'(d1); m_d2 = DW'(d2);
`endif
        m_latch = 1;
      end
    end
    #1;
    check("transfer",          64'(transfer),                64'(m_transfer));
    check("transfer_count",    64'(transfer_count),          64'(m_count));
    check("transfer_mismatch", 64'(transfer_mismatch),       64'(m_mm));
    check("mismatch_latch",    64'(transfer_mismatch_latch), 64'(m_latch));
    check("mismatch_tdata1",   64'(mismatch_tdata1),         64'(m_d1));
    check("mismatch_tdata2",   64'(mismatch_tdata2),         64'(m_d2));
  endtask

  initial begin
    // Reset with both sources valid: nothing may be consumed.
    cycle(1, 1, 5, 1, 6);
    cycle(1, 1, 5, 1, 6);
    check("reset_count_literal", 64'(transfer_count), 64'(0));

    // Identical counting sequence, full throughput.
    for (int i = 0; i < 10; i++) cycle(0, 1, i, 1, i);
    check("seq_count_literal", 64'(transfer_count), 64'(10));
    check("seq_latch_literal", 64'(transfer_mismatch_latch), 64'(0));
    cycle(0, 0, 0, 0, 0);

    // Stream 1 waits alone, then pairs.
    for (int i = 0; i < 5; i++) cycle(0, 1, 7, 0, 0);
    cycle(0, 1, 7, 1, 7);
    check("pair_count_literal", 64'(transfer_count), 64'(11));

    // One mismatch in the middle, then a second one.
    cycle(0, 1, 3, 1, 3);
    cycle(0, 1, 4, 1, 5);
    check("mm1_d1_literal", 64'(mismatch_tdata1), 64'(4));
    check("mm1_d2_literal", 64'(mismatch_tdata2), 64'(5));
    cycle(0, 1, 6, 1, 6);
    check("latch_sticky_literal", 64'(transfer_mismatch_latch), 64'(1));
    cycle(0, 1, 8, 1, 9);
    cycle(0, 0, 0, 0, 0);
`ifdef AXI_STREAM_COMPARATOR_FIRST_MISMATCH_EN
    check("mm2_d1_literal", 64'(mismatch_tdata1), 64'(4));
`else
    check("mm2_d1_literal", 64'(mismatch_tdata1), 64'(8));
`endif

    // Mid-stream reset after a mismatch, then counting restarts.
    cycle(1, 1, 1, 1, 2);
    check("rst_latch_literal", 64'(transfer_mismatch_latch), 64'(0));
    cycle(0, 1, 2, 1, 2);
    check("restart_count_literal", 64'(transfer_count), 64'(1));

    // Random beats from a small data set so matches and mismatches both occur.
    for (int i = 0; i < 80; i++)
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3));

    // Wrap: after reset, 17 matching beats leave a 4-bit count at 1.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) cycle(0, 1, i, 1, i);
    check("wrap_count_literal", 64'(transfer_count), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_stream_comparator.md
Name: axi_stream_comparator

Overview:
- Lock-step checker for two AXI-Stream sources.
- Consumes one beat from each input only when both present valid data, then compares the two tdata words.
- Reports each transfer, a running transfer count, per-transfer and sticky mismatch flags, and the offending data pair.
- Sits at the end of a verification/self-test pipeline as the sink for two streams that should carry identical sequences.

Parameters:
- DATA_BITS, 32, width of in1_tdata, in2_tdata, mismatch_tdata1, mismatch_tdata2.
- COUNT_BITS, 32, width of transfer_count.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in1_tvalid  input  1  stream 1 valid.
- in1_tready  output  1  stream 1 ready.
- in1_tdata  input  DATA_BITS  stream 1 data.
- in2_tvalid  input  1  stream 2 valid.
- in2_tready  output  1  stream 2 ready.
- in2_tdata  input  DATA_BITS  stream 2 data.
- transfer  output  1  one-cycle pulse per completed paired transfer.
- transfer_count  output  COUNT_BITS  number of paired transfers since reset.
- transfer_mismatch  output  1  one-cycle pulse: the reported transfer had unequal data.
- transfer_mismatch_latch  output  1  sticky: any mismatch since reset.
- mismatch_tdata1  output  DATA_BITS  stream 1 data of the captured mismatch.
- mismatch_tdata2  output  DATA_BITS  stream 2 data of the captured mismatch.

Behaviour:
- Handshake, combinational:
  - in1_tready = !rst && in2_tvalid.
  - in2_tready = !rst && in1_tvalid.
  - No combinational path from tready to tvalid is created.
- Paired handshake fires ("hs") when in1_tvalid && in2_tvalid && !rst. Both streams accept exactly one beat in that cycle.
- A stream that is valid alone is held, not consumed. Its tvalid/tdata must stay stable per AXI; the block relies on this.
- All status outputs are registered; latency is 1 cycle after hs.
- On the rising edge ending an hs cycle:
  - transfer <= 1.
  - transfer_count <= transfer_count + 1, wrapping modulo 2^COUNT_BITS.
  - transfer_mismatch <= (in1_tdata != in2_tdata).
  - On mismatch: transfer_mismatch_latch <= 1; mismatch_tdata1 <= in1_tdata; mismatch_tdata2 <= in2_tdata.
- On any edge without hs:
  - transfer <= 0 and transfer_mismatch <= 0.
  - Count, latch and mismatch data hold.
- Back-to-back hs every cycle gives transfer held high continuously and a count increment every cycle (full throughput).
- Equal data never modifies mismatch_tdata1/2 or the latch.
- Reset (any cycle, including mid-stream): all outputs are 0 the following cycle; tready is forced 0 while rst is high; a beat presented during rst is not consumed.
- Count wrap: at all-ones, the next hs yields 0. No other side effect.
- Comparison is full-width bitwise equality. X/Z handling is not specified; inputs are assumed driven.

Optional Feature:
- Macro: AXI_STREAM_COMPARATOR_FIRST_MISMATCH_EN.
- Defined: mismatch_tdata1/2 capture only when transfer_mismatch_latch is currently 0, so they retain the first mismatch since reset. transfer_mismatch still pulses for every mismatch.
- Undefined: capture on every mismatch, so they hold the most recent mismatch.

Test Plan:
- Both sources valid every cycle with identical 0,1,2,…,9 -> tready both 1; transfer high cycles 1–10 after start; transfer_count=10; latch=0.
- in1_tvalid=1 alone for 5 cycles, then in2_tvalid=1, both tdata=0x7 -> no transfer during the 5 cycles; in2_tready=1 and in1_tready=0 during them; single transfer one cycle after pairing; count=1.
- Paired beats 3/3, 4/5, 6/6 -> transfer_mismatch pulses only for the second beat; mismatch_tdata1=4, mismatch_tdata2=5; latch stays 1 afterwards.
- Mismatches 4/5 then 8/9 -> default build reports 8/9; with AXI_STREAM_COMPARATOR_FIRST_MISMATCH_EN it reports 4/5.
- COUNT_BITS=4, 17 paired matching beats -> transfer_count=1 after wrap.
- Assert rst mid-stream after a mismatch -> next cycle: count=0, latch=0, mismatch data=0, tready=0; counting restarts from 1 after rst deasserts.
